// File: rtl/control_sequencer_if.sv
// Datapath control bundle: the instruction word flowing into the sequencer
// and every strobe, ALU select and debug output flowing back out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        HIin, LOin, HIout, LOout;
  logic        Zhighout, Zlowout, Zin, Yin;
  logic        MDRout, MDRin, MARin;
  logic        PCout, PCin, IRin, IncPC, Cout;
  logic        read, write;
  logic [4:0]  opcode;
  logic        run;
  logic [3:0]  present_state;

  // Sequencer side: consumes IR, drives all control outputs
  modport master (
    input  IR,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output HIin, LOin, HIout, LOout,
    output Zhighout, Zlowout, Zin, Yin,
    output MDRout, MDRin, MARin,
    output PCout, PCin, IRin, IncPC, Cout,
    output read, write,
    output opcode, run, present_state
  );

  // Datapath side: supplies IR, obeys the control outputs
  modport slave (
    output IR,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  HIin, LOin, HIout, LOout,
    input  Zhighout, Zlowout, Zin, Yin,
    input  MDRout, MDRin, MARin,
    input  PCout, PCin, IRin, IncPC, Cout,
    input  read, write,
    input  opcode, run, present_state
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore-style control sequencer: shared three-cycle fetch, then an
// opcode-dependent execute sequence of up to five more cycles.
// A halt instruction parks the machine until clear.
module control_sequencer (
  input  logic                       clock,
  input  logic                       clear,
  control_sequencer_if.master        bus
);

  typedef enum logic [3:0] {
    S_DEFAULT = 4'd0,
    S_T0      = 4'd1,
    S_T1      = 4'd2,
    S_T2      = 4'd3,
    S_T3      = 4'd4,
    S_T4      = 4'd5,
    S_T5      = 4'd6,
    S_T6      = 4'd7,
    S_T7      = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] ir_op;
  logic       unused_ir;
  logic       is_mem;
  logic       is_ldi;
  logic       is_alu;
  logic       is_addi;

  // Only the top five IR bits carry the opcode; the rest belong to the datapath
  assign ir_op     = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  // Instruction class flags shared by the next-state and output decoders
  always_comb begin
    is_mem  = (ir_op == OP_LD) || (ir_op == OP_ST);
    is_ldi  = (ir_op == OP_LDI);
    is_alu  = (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
              (ir_op == OP_AND) || (ir_op == OP_OR);
    is_addi = (ir_op == OP_ADDI);
  end

  // State register; clear abandons any partial instruction, even from HALT
  always_ff @(posedge clock) begin
    if (clear) state_q <= S_DEFAULT;
    else       state_q <= state_d;
  end

  // Next state: linear fetch, opcode-dependent execute length, HALT is sticky
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DEFAULT: state_d = S_T0;
      S_T0:      state_d = S_T1;
      S_T1:      state_d = S_T2;
      S_T2:      state_d = S_T3;
      S_T3: begin
        if (ir_op == OP_HALT)                          state_d = S_HALT;
        else if (is_mem || is_ldi || is_alu || is_addi) state_d = S_T4;
        else                                            state_d = S_T0;
      end
      S_T4:      state_d = S_T5;
      S_T5:      state_d = is_mem ? S_T6 : S_T0;
      S_T6:      state_d = S_T7;
      S_T7:      state_d = S_T0;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_DEFAULT;
    endcase
  end

  // Output decode from the registered state and the opcode field only
  always_comb begin
    bus.Gra = 1'b0;      bus.Grb = 1'b0;      bus.Grc = 1'b0;
    bus.Rin = 1'b0;      bus.Rout = 1'b0;     bus.BAout = 1'b0;
    bus.HIin = 1'b0;     bus.LOin = 1'b0;     bus.HIout = 1'b0;
    bus.LOout = 1'b0;    bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
    bus.Zin = 1'b0;      bus.Yin = 1'b0;      bus.MDRout = 1'b0;
    bus.MDRin = 1'b0;    bus.MARin = 1'b0;    bus.PCout = 1'b0;
    bus.PCin = 1'b0;     bus.IRin = 1'b0;     bus.IncPC = 1'b0;
    bus.Cout = 1'b0;     bus.read = 1'b0;     bus.write = 1'b0;
    bus.opcode        = 5'b00000;
    bus.run           = (state_q != S_HALT);
    bus.present_state = state_q;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (is_mem || is_ldi) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (is_alu || is_addi) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = ir_op;
        end else if (is_mem || is_ldi || is_addi) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = OP_ADD;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_mem) begin
          bus.MARin = 1'b1;
        end else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        if (ir_op == OP_ST) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end else begin
          bus.read = 1'b1; bus.MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (ir_op == OP_ST) begin
          bus.write = 1'b1;
        end else begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a micro-program table model checked every
// cycle, plus directed literal checks on the key instruction sequences.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  localparam logic [23:0] M_GRA    = 24'h800000;
  localparam logic [23:0] M_GRB    = 24'h400000;
  localparam logic [23:0] M_GRC    = 24'h200000;
  localparam logic [23:0] M_RIN    = 24'h100000;
  localparam logic [23:0] M_ROUT   = 24'h080000;
  localparam logic [23:0] M_BAOUT  = 24'h040000;
  localparam logic [23:0] M_HIOUT  = 24'h008000;
  localparam logic [23:0] M_LOOUT  = 24'h004000;
  localparam logic [23:0] M_ZHIGH  = 24'h002000;
  localparam logic [23:0] M_ZLOW   = 24'h001000;
  localparam logic [23:0] M_ZIN    = 24'h000800;
  localparam logic [23:0] M_YIN    = 24'h000400;
  localparam logic [23:0] M_MDROUT = 24'h000200;
  localparam logic [23:0] M_MDRIN  = 24'h000100;
  localparam logic [23:0] M_MARIN  = 24'h000080;
  localparam logic [23:0] M_PCOUT  = 24'h000040;
  localparam logic [23:0] M_PCIN   = 24'h000020;
  localparam logic [23:0] M_IRIN   = 24'h000010;
  localparam logic [23:0] M_INCPC  = 24'h000008;
  localparam logic [23:0] M_COUT   = 24'h000004;
  localparam logic [23:0] M_READ   = 24'h000002;
  localparam logic [23:0] M_WRITE  = 24'h000001;
  localparam logic [23:0] M_BUSDRV = M_PCOUT | M_ZLOW | M_ZHIGH | M_MDROUT |
                                     M_ROUT | M_HIOUT | M_LOOUT;

  localparam int C_LD = 0, C_LDI = 1, C_ST = 2, C_ALU = 3,
                 C_ADDI = 4, C_HALT = 5, C_UNDEF = 6;

  localparam logic [31:0] IR_LD    = 32'h01080065;
  localparam logic [31:0] IR_ADD   = 32'h19890000;
  localparam logic [31:0] IR_ST    = 32'h10000000;
  localparam logic [31:0] IR_LDI   = 32'h08000000;
  localparam logic [31:0] IR_SUB   = 32'h20000000;
  localparam logic [31:0] IR_AND   = 32'h28000000;
  localparam logic [31:0] IR_OR    = 32'h30000000;
  localparam logic [31:0] IR_ADDI  = 32'h60000000;
  localparam logic [31:0] IR_HALT  = 32'hD8000000;
  localparam logic [31:0] IR_UNDEF = 32'hF8000000;

  logic [23:0] prog [0:6][0:7];
  int          plen [0:6];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          check_en = 1'b0;
  int          m_state  = 0;
  logic [23:0] dut_sv;

  assign dut_sv = {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                   bus.HIin, bus.LOin, bus.HIout, bus.LOout, bus.Zhighout,
                   bus.Zlowout, bus.Zin, bus.Yin, bus.MDRout, bus.MDRin,
                   bus.MARin, bus.PCout, bus.PCin, bus.IRin, bus.IncPC,
                   bus.Cout, bus.read, bus.write};

  function automatic int op_class(logic [4:0] op);
    case (op)
      5'b00000:                            return C_LD;
      5'b00001:                            return C_LDI;
      5'b00010:                            return C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_ALU;
      5'b01100:                            return C_ADDI;
      5'b11011:                            return C_HALT;
      default:                             return C_UNDEF;
    endcase
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(logic clr, logic [31:0] ir);
    clear  = clr;
    bus.IR = ir;
  endtask

  task automatic wait_state(int code, int budget, string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (32'(bus.present_state) == 32'(code)) return;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting for state %0d, got %0d", name, code, bus.present_state);
  endtask

  // Model: instruction length comes from the class table; halt parks in state 9
  always @(posedge clock) begin
    int t, c;
    c = op_class(bus.IR[31:27]);
    if (clear)              m_state <= 0;
    else if (m_state == 0)  m_state <= 1;
    else if (m_state == 9)  m_state <= 9;
    else begin
      t = m_state - 1;
      if (t == 3 && c == C_HALT)  m_state <= 9;
      else if (t + 1 >= plen[c])  m_state <= 1;
      else                        m_state <= m_state + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    logic [23:0] exp_sv;
    logic [4:0]  exp_op;
    int t, c;
    if (check_en) begin
      c = op_class(bus.IR[31:27]);
      exp_sv = '0;
      exp_op = 5'b00000;
      if (m_state >= 1 && m_state <= 8) begin
        t = m_state - 1;
        exp_sv = prog[c][t];
        if (t == 4) exp_op = (c == C_ALU) ? bus.IR[31:27] : 5'b00011;
      end
      check_output("model_state",   32'(bus.present_state), 32'(m_state));
      check_output("model_strobes", 32'(dut_sv), 32'(exp_sv));
      check_output("model_opcode",  32'(bus.opcode), 32'(exp_op));
      check_output("model_run",     32'(bus.run), 32'(m_state != 9));
      check_output("rw_exclusive",  32'(bus.read & bus.write), 32'd0);
      check_output("one_bus_driver", 32'($countones(dut_sv & M_BUSDRV) <= 1), 32'd1);
    end
  end

  initial begin
    for (int c = 0; c < 7; c++) begin
      for (int t = 0; t < 8; t++) prog[c][t] = '0;
      prog[c][0] = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
      prog[c][1] = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
      prog[c][2] = M_MDROUT | M_IRIN;
    end
    prog[C_LD][3]   = M_GRB | M_BAOUT | M_YIN;
    prog[C_LD][4]   = M_COUT | M_ZIN;
    prog[C_LD][5]   = M_ZLOW | M_MARIN;
    prog[C_LD][6]   = M_READ | M_MDRIN;
    prog[C_LD][7]   = M_MDROUT | M_GRA | M_RIN;
    prog[C_LDI][3]  = M_GRB | M_BAOUT | M_YIN;
    prog[C_LDI][4]  = M_COUT | M_ZIN;
    prog[C_LDI][5]  = M_ZLOW | M_GRA | M_RIN;
    prog[C_ST][3]   = M_GRB | M_BAOUT | M_YIN;
    prog[C_ST][4]   = M_COUT | M_ZIN;
    prog[C_ST][5]   = M_ZLOW | M_MARIN;
    prog[C_ST][6]   = M_GRA | M_ROUT | M_MDRIN;
    prog[C_ST][7]   = M_WRITE;
    prog[C_ALU][3]  = M_GRB | M_ROUT | M_YIN;
    prog[C_ALU][4]  = M_GRC | M_ROUT | M_ZIN;
    prog[C_ALU][5]  = M_ZLOW | M_GRA | M_RIN;
    prog[C_ADDI][3] = M_GRB | M_ROUT | M_YIN;
    prog[C_ADDI][4] = M_COUT | M_ZIN;
    prog[C_ADDI][5] = M_ZLOW | M_GRA | M_RIN;
    plen[C_LD] = 8; plen[C_LDI] = 6; plen[C_ST] = 8; plen[C_ALU] = 6;
    plen[C_ADDI] = 6; plen[C_HALT] = 4; plen[C_UNDEF] = 4;

    apply_stimulus(1'b1, IR_LD);
    check_en = 1'b1;

    // Reset and first fetch
    @(negedge clock);
    check_output("reset_state", 32'(bus.present_state), 32'd0);
    check_output("reset_run", 32'(bus.run), 32'd1);
    apply_stimulus(1'b0, IR_LD);
    @(negedge clock);
    check_output("first_fetch_t0", 32'(bus.present_state), 32'd1);

    // ld R2,0x65(R1)
    wait_state(5, 20, "ld_t4");
    check_output("ld_t4_opcode", 32'(bus.opcode), 32'b00011);
    wait_state(7, 20, "ld_t6");
    check_output("ld_t6_read_mdrin", 32'({bus.read, bus.MDRin}), 32'b11);
    wait_state(8, 20, "ld_t7");
    check_output("ld_t7_mdrout_gra_rin", 32'({bus.MDRout, bus.Gra, bus.Rin}), 32'b111);
    @(negedge clock);
    check_output("ld_back_to_t0", 32'(bus.present_state), 32'd1);

    // add R3,R1,R2
    apply_stimulus(1'b0, IR_ADD);
    wait_state(5, 20, "add_t4");
    check_output("add_t4_grc_rout_zin", 32'({bus.Grc, bus.Rout, bus.Zin}), 32'b111);
    check_output("add_t4_opcode", 32'(bus.opcode), 32'b00011);
    wait_state(6, 20, "add_t5");
    check_output("add_t5_zlow_gra_rin", 32'({bus.Zlowout, bus.Gra, bus.Rin}), 32'b111);
    @(negedge clock);
    check_output("add_back_to_t0", 32'(bus.present_state), 32'd1);

    // st
    apply_stimulus(1'b0, IR_ST);
    wait_state(7, 20, "st_t6");
    check_output("st_t6_gra_rout_mdrin_read", 32'({bus.Gra, bus.Rout, bus.MDRin, bus.read}), 32'b1110);
    wait_state(8, 20, "st_t7");
    check_output("st_t7_write_read", 32'({bus.write, bus.read}), 32'b10);
    wait_state(1, 20, "st_done");

    // Remaining ALU-class and immediate instructions, checked by the model
    apply_stimulus(1'b0, IR_SUB);
    wait_state(5, 20, "sub_t4");
    check_output("sub_t4_opcode", 32'(bus.opcode), 32'b00100);
    wait_state(1, 20, "sub_done");
    apply_stimulus(1'b0, IR_AND);
    wait_state(5, 20, "and_t4");
    check_output("and_t4_opcode", 32'(bus.opcode), 32'b00101);
    wait_state(1, 20, "and_done");
    apply_stimulus(1'b0, IR_OR);
    wait_state(1, 20, "or_done");
    apply_stimulus(1'b0, IR_LDI);
    wait_state(1, 20, "ldi_done");
    apply_stimulus(1'b0, IR_ADDI);
    wait_state(4, 20, "addi_t3");
    check_output("addi_t3_rout", 32'(bus.Rout), 32'd1);
    wait_state(1, 20, "addi_done");

    // Undefined opcode: nop, four cycles T0..T3
    apply_stimulus(1'b0, IR_UNDEF);
    repeat (3) @(negedge clock);
    check_output("undef_t3_state", 32'(bus.present_state), 32'd4);
    check_output("undef_t3_strobes", 32'(dut_sv), 32'd0);
    @(negedge clock);
    check_output("undef_4cycle_t0", 32'(bus.present_state), 32'd1);

    // clear during T5 of ld
    apply_stimulus(1'b0, IR_LD);
    wait_state(6, 20, "ld2_t5");
    apply_stimulus(1'b1, IR_LD);
    @(negedge clock);
    check_output("midclear_state", 32'(bus.present_state), 32'd0);
    check_output("midclear_strobes", 32'(dut_sv), 32'd0);
    apply_stimulus(1'b0, IR_LD);
    @(negedge clock);
    check_output("midclear_refetch", 32'(bus.present_state), 32'd1);

    // halt, then park, then clear out of HALT
    apply_stimulus(1'b0, IR_HALT);
    wait_state(4, 20, "halt_t3");
    check_output("halt_t3_strobes", 32'(dut_sv), 32'd0);
    @(negedge clock);
    check_output("halt_entered", 32'(bus.present_state), 32'd9);
    check_output("halt_run", 32'(bus.run), 32'd0);
    repeat (12) @(negedge clock);
    check_output("halt_held_state", 32'(bus.present_state), 32'd9);
    check_output("halt_held_strobes", 32'(dut_sv), 32'd0);
    apply_stimulus(1'b1, IR_HALT);
    @(negedge clock);
    check_output("halt_clear_state", 32'(bus.present_state), 32'd0);
    check_output("halt_clear_run", 32'(bus.run), 32'd1);
    apply_stimulus(1'b0, IR_LD);
    @(negedge clock);
    check_output("halt_clear_refetch", 32'(bus.present_state), 32'd1);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port: IR  in  32  instruction register contents from datapath; only IR[31:27] decoded.
REQ-004 SHALL have outputs, 1 bit each, datapath strobes: Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, HIout, LOout, Zhighout, Zlowout, Zin, Yin, MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC, Cout, read, write.
REQ-005 SHALL have port: opcode  out  5  ALU operation select, meaningful only while Zin=1, else 5'b00000.
REQ-006 SHALL have port: run  out  1  high while executing, low in HALT.
REQ-007 SHALL have port: present_state  out  4  debug state code.

Function
REQ-010 SHALL be a Moore FSM: outputs are a combinational decode of the registered state plus IR[31:27]; no output asserted unless listed for the current state.
REQ-011 SHALL use state codes Default=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, HALT=9; present_state reflects the code.
REQ-012 SHALL hold each state exactly one clock; Default->T0 unconditionally.
REQ-013 SHALL fetch identically for all instructions: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,read,MDRin; T2 MDRout,IRin; then T3.
REQ-014 SHALL decode IR[31:27] from T3 onward (IR stable after T2 edge): ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, halt=11011.
REQ-015 ld SHALL run T3 Grb,BAout,Yin; T4 Cout,Zin,opcode=00011; T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-016 ldi SHALL run T3 Grb,BAout,Yin; T4 Cout,Zin,opcode=00011; T5 Zlowout,Gra,Rin; then T0.
REQ-017 st SHALL run T3-T5 as ld; T6 Gra,Rout,MDRin with read=0; T7 write; then T0.
REQ-018 add/sub/and/or SHALL run T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,opcode=IR[31:27]; T5 Zlowout,Gra,Rin; then T0.
REQ-019 addi SHALL run T3 Grb,Rout,Yin; T4 Cout,Zin,opcode=00011; T5 Zlowout,Gra,Rin; then T0.
REQ-020 halt SHALL assert no strobes in T3 and enter HALT; HALT holds all strobes 0 and run=0 until clear.
REQ-021 Undefined opcode SHALL assert no strobes in T3 and return to T0 (nop, 4-cycle instruction).
REQ-022 read and write SHALL never be high in the same cycle; at most one of PCout, Zlowout, Zhighout, MDRout, Rout, HIout, LOout SHALL be high per cycle (single bus driver).

Reset
REQ-030 clear=1 at a rising edge SHALL force state Default regardless of current state, including mid-instruction and HALT; the partial instruction is abandoned.
REQ-031 In Default, all strobes SHALL be 0, opcode=00000, run=1, present_state=0.
REQ-032 After clear deasserts, the first fetch cycle T0 SHALL occur on the following edge.

Verification
REQ-040 clear 1 cycle, IR=0x01080065 (ld R2,0x65(R1)) -> states 0,1..8,1; T6 read=1,MDRin=1; T7 MDRout=Gra=Rin=1; T4 opcode=00011.
REQ-041 IR=0x19890000 (add R3,R1,R2) -> T4 Grc=Rout=Zin=1, opcode=00011; T5 Zlowout=Gra=Rin=1; next state T0 after T5.
REQ-042 IR=0x10000000 (st) -> T6 Gra=Rout=MDRin=1, read=0; T7 write=1, read=0; no cycle with two bus drivers.
REQ-043 IR=0xD8000000 (halt) -> T3 then HALT, run=0, all strobes 0 for 10+ cycles; clear -> Default, run=1.
REQ-044 clear asserted during T5 of ld -> next state Default, all strobes 0; refetch begins two edges after clear.
REQ-045 IR=0xF8000000 (undefined 11111) -> T3 all strobes 0, then T0; instruction takes 4 cycles.
